// File: rtl/div_unit.sv
`timescale 1ns/1ps
// div_unit: multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring radix-2,
// one quotient bit per cycle.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             launch request, honoured only when idle
//   func3             100 DIV, 101 DIVU, 110 REM, 111 REMU (sampled with start)
//   operand1/2        dividend / divisor (sampled with start)
//   flush             abort an operation in progress
//   busy              stall request while computing
//   done              one-cycle pulse, result valid
//   result            quotient or remainder, held until the next done
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            rem_sel_q, rem_sel_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            busy_d, done_d;
  logic [XLEN-1:0] result_d;

  // Operand decode for the launch cycle
  logic            op1_neg, op2_neg, div_zero, ovf;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN-1:0] int_min;

  assign int_min  = {1'b1, {(XLEN-1){1'b0}}};
  assign op1_neg  = ~func3[0] & operand1[XLEN-1];
  assign op2_neg  = ~func3[0] & operand2[XLEN-1];
  assign abs1     = op1_neg ? XLEN'(0) - operand1 : operand1;
  assign abs2     = op2_neg ? XLEN'(0) - operand2 : operand2;
  assign div_zero = (operand2 == '0);
  assign ovf      = ~func3[0] && (operand1 == int_min) && (operand2 == '1);

  // Trial subtraction: since rem < divisor, the XLEN+1-bit difference's MSB is the borrow
  logic [XLEN:0]   shifted, diff;
  logic            borrow;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign borrow  = diff[XLEN];

  // Sign fix-up of the unsigned results
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign quo_fix = qneg_q ? XLEN'(0) - quo_q : quo_q;
  assign rem_fix = rneg_q ? XLEN'(0) - rem_q : rem_q;

  // func3[2] only identifies the M-extension divide group, already decoded into start
  logic unused_func3;
  assign unused_func3 = func3[2];

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    rem_sel_d = rem_sel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = result;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          rem_sel_d = func3[1];
          cnt_d     = '0;
          if (div_zero) begin
            quo_d    = '1;
            rem_d    = operand1;
            qneg_d   = 1'b0;
            rneg_d   = 1'b0;
            result_d = func3[1] ? operand1 : '1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (ovf) begin
            quo_d    = int_min;
            rem_d    = '0;
            qneg_d   = 1'b0;
            rneg_d   = 1'b0;
            result_d = func3[1] ? '0 : int_min;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            quo_d   = abs1;
            rem_d   = '0;
            dvs_d   = abs2;
            qneg_d  = op1_neg ^ op2_neg;
            rneg_d  = op1_neg;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d  = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quo_d  = {quo_q[XLEN-2:0], ~borrow};
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quo_d    = quo_fix;
          rem_d    = rem_fix;
          result_d = rem_sel_q ? rem_fix : quo_fix;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      rem_sel_q <= rem_sel_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      busy      <= busy_d;
      done      <= done_d;
      result    <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// tb_div_unit: directed self-checking bench for div_unit (XLEN=32).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .func3    (func3),
    .operand1 (operand1),
    .operand2 (operand2),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one op; exp_lat = edges after the start edge until done (33 normal, 0 special)
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int          n;
    int          nbusy;
    logic [31:0] prev;
    bit          glitch;
    prev   = result;
    glitch = 1'b0;
    nbusy  = 0;
    n      = 0;
    @(negedge clk);
    start = 1'b1; func3 = f3; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    while (!done && n < 100) begin
      if (busy) nbusy++;
      if (result !== prev) glitch = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, " result_stable"}, 32'(glitch), 32'd0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " result_hold"}, result, exp);
    chk({tag, " no_relaunch"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'b000;
    operand1 = '0; operand2 = '0;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_7_m2",   F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_7_m2",   F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
    run_op("div_by0",    F_DIV,  32'h1234, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("rem_by0",    F_REM,  32'h1234, 32'd0, 32'h1234, 0, 1'b0);
    run_op("divu_by0",   F_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    run_op("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_op("divu_big",   F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    run_op("remu_max",   F_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 1'b0);

    // flush and start together in IDLE: no launch (a div-by-zero would pulse done at once)
    @(negedge clk);
    start = 1'b1; flush = 1'b1; func3 = F_DIV; operand1 = 32'h55; operand2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start done", 32'(done), 32'd0);
    chk("flush_start busy", 32'(busy), 32'd0);

    // flush at CALC cycle 10
    prev = result;
    @(negedge clk);
    start = 1'b1; func3 = F_DIVU; operand1 = 32'd1000; operand2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush result", result, prev);
    saw_done = done;
    repeat (2) begin @(posedge clk); #1; saw_done = saw_done | done; end
    chk("flush no_done", 32'(saw_done), 32'd0);
    run_op("divu_after_flush", F_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1'b0);

    // async reset at CALC cycle 20
    @(negedge clk);
    start = 1'b1; func3 = F_DIVU; operand1 = 32'h55; operand2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    chk("arst result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    // start held high for the whole operation
    run_op("divu_max_1_held", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
